// File: rtl/syndrome_compute.sv
// Sparse-dense syndrome s = c0*h0 + c1*h1 over GF(2)[x]/(x^R - 1).
// Optional macro SYND_WEIGHT_EN adds a bit-serial Hamming weight pass.
module syndrome_compute #(
    parameter int R     = 127,
    parameter int W     = 5,
    parameter int POS_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [R-1:0]         c0,
    input  logic [R-1:0]         c1,
    input  logic [W*POS_W-1:0]   h0_pos_flat,
    input  logic [W*POS_W-1:0]   h1_pos_flat,
    output logic [R-1:0]         s_out,
    output logic [POS_W:0]       s_weight,
    output logic                 err,
    output logic                 done
);

    localparam int NW = (W > 1) ? $clog2(2 * W) : 1;
    localparam int HW = 2 * W * POS_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
`ifdef SYND_WEIGHT_EN
        S_WEIGHT,
`endif
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [R-1:0]      c0_q, c0_d;
    logic [R-1:0]      c1_q, c1_d;
    logic [HW-1:0]     hpos_q, hpos_d;
    logic [R-1:0]      acc_q, acc_d;
    logic [NW-1:0]     n_q, n_d;
    logic              elat_q, elat_d;
    logic [R-1:0]      s_out_q, s_out_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    logic [POS_W-1:0]  pos;
    logic              oor;
    logic [R-1:0]      c_sel;
    logic [POS_W:0]    sh;
    logic [2*R-1:0]    dbl;
    logic [2*R-1:0]    dbl_sh;
    logic [R-1:0]      rot;
    logic              last;

    // Shared rotator: rotl(x,p) is the low half of {x,x} >> (R-p).
    always_comb begin
        pos = '0;
        for (int k = 0; k < 2 * W; k++) begin
            if (n_q == NW'(k)) pos = hpos_q[k*POS_W +: POS_W];
        end
        oor    = {1'b0, pos} >= (POS_W + 1)'(R);
        c_sel  = (n_q < NW'(W)) ? c0_q : c1_q;
        sh     = oor ? '0 : ((POS_W + 1)'(R) - {1'b0, pos});
        dbl    = {c_sel, c_sel};
        dbl_sh = dbl >> sh;
        rot    = dbl_sh[R-1:0];
        last   = (n_q == NW'(2 * W - 1));
    end

`ifdef SYND_WEIGHT_EN
    logic [POS_W:0] bit_q, bit_d;
    logic [POS_W:0] cnt_q, cnt_d;
    logic [POS_W:0] s_weight_q, s_weight_d;
    logic           bit_v;

    always_comb begin
        bit_v = 1'b0;
        for (int k = 0; k < R; k++) begin
            if (bit_q == (POS_W + 1)'(k)) bit_v = acc_q[k];
        end
    end

    assign s_weight = s_weight_q;
`else
    assign s_weight = '0;
`endif

    always_comb begin
        state_d = state_q;
        c0_d    = c0_q;
        c1_d    = c1_q;
        hpos_d  = hpos_q;
        acc_d   = acc_q;
        n_d     = n_q;
        elat_d  = elat_q;
        s_out_d = s_out_q;
        err_d   = err_q;
        done_d  = done_q;
`ifdef SYND_WEIGHT_EN
        bit_d      = bit_q;
        cnt_d      = cnt_q;
        s_weight_d = s_weight_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                done_d = 1'b0;
                if (start) begin
                    c0_d    = c0;
                    c1_d    = c1;
                    hpos_d  = {h1_pos_flat, h0_pos_flat};
                    acc_d   = '0;
                    n_d     = '0;
                    elat_d  = 1'b0;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                if (oor) elat_d = 1'b1;
                else     acc_d  = acc_q ^ rot;
                n_d = n_q + 1'b1;
                if (last) begin
`ifdef SYND_WEIGHT_EN
                    bit_d   = '0;
                    cnt_d   = '0;
                    state_d = S_WEIGHT;
`else
                    s_out_d = elat_d ? '0 : acc_d;
                    err_d   = elat_d;
                    state_d = S_DONE;
`endif
                end
            end
`ifdef SYND_WEIGHT_EN
            S_WEIGHT: begin
                cnt_d = cnt_q + {{POS_W{1'b0}}, bit_v};
                bit_d = bit_q + 1'b1;
                if (bit_q == (POS_W + 1)'(R - 1)) begin
                    s_out_d    = elat_q ? '0 : acc_q;
                    s_weight_d = elat_q ? '0 : cnt_d;
                    err_d      = elat_q;
                    state_d    = S_DONE;
                end
            end
`endif
            S_DONE: begin
                done_d = 1'b1;
                if (!start) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            c0_q    <= '0;
            c1_q    <= '0;
            hpos_q  <= '0;
            acc_q   <= '0;
            n_q     <= '0;
            elat_q  <= 1'b0;
            s_out_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c0_q    <= c0_d;
            c1_q    <= c1_d;
            hpos_q  <= hpos_d;
            acc_q   <= acc_d;
            n_q     <= n_d;
            elat_q  <= elat_d;
            s_out_q <= s_out_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

`ifdef SYND_WEIGHT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_q      <= '0;
            cnt_q      <= '0;
            s_weight_q <= '0;
        end else begin
            bit_q      <= bit_d;
            cnt_q      <= cnt_d;
            s_weight_q <= s_weight_d;
        end
    end
`endif

    assign s_out = s_out_q;
    assign err   = err_q;
    assign done  = done_q;

endmodule

// File: tb/tb_syndrome_compute.sv
// Directed bench for syndrome_compute with R=5, W=3, POS_W=8.
module tb_syndrome_compute;

    localparam int R  = 5;
    localparam int W  = 3;
    localparam int PW = 8;
`ifdef SYND_WEIGHT_EN
    localparam int LAT = 2 * W + R + 1;
    localparam bit WEN = 1'b1;
`else
    localparam int LAT = 2 * W + 1;
    localparam bit WEN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [R-1:0]    c0, c1;
    logic [W*PW-1:0] h0, h1;
    logic [R-1:0]    s_out;
    logic [PW:0]     s_weight;
    logic            err;
    logic            done;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    localparam logic [W*PW-1:0] H0   = {8'd4, 8'd1, 8'd0};
    localparam logic [W*PW-1:0] H1   = {8'd3, 8'd2, 8'd1};
    localparam logic [W*PW-1:0] H0_E = {8'd4, 8'd5, 8'd0};

    syndrome_compute #(.R(R), .W(W), .POS_W(PW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .c0          (c0),
        .c1          (c1),
        .h0_pos_flat (h0),
        .h1_pos_flat (h1),
        .s_out       (s_out),
        .s_weight    (s_weight),
        .err         (err),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Start a run, scramble inputs after capture, measure edges to done.
    task automatic run(input string tag, input logic [R-1:0] a,
                       input logic [R-1:0] b, input logic [W*PW-1:0] p0,
                       input logic [W*PW-1:0] p1, input logic [R-1:0] s_exp,
                       input int w_exp, input logic e_exp);
        int lat;
        @(negedge clk);
        c0 = a; c1 = b; h0 = p0; h1 = p1; start = 1'b1;
        @(posedge clk); #1;
        c0 = ~a; c1 = ~b; h0 = ~p0; h1 = ~p1;
        lat = 0;
        while (!done && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".lat"}, lat, LAT);
        check({tag, ".s"}, 32'(s_out), 32'(s_exp));
        check({tag, ".err"}, 32'(err), 32'(e_exp));
        check({tag, ".w"}, 32'(s_weight), WEN ? w_exp : 0);
    endtask

    task automatic drop(input string tag);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check({tag, ".drop"}, 32'(done), 0);
    endtask

    initial begin
        logic [R-1:0] keep;
        int seen;
        rst_n = 1'b0; start = 1'b0;
        c0 = '0; c1 = '0; h0 = '0; h1 = '0;
        #12;
        check("rst.s", 32'(s_out), 0);
        check("rst.w", 32'(s_weight), 0);
        check("rst.err", 32'(err), 0);
        check("rst.done", 32'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run("t1", 5'b01100, 5'b00010, H0, H1, 5'b01110, 3, 1'b0);
        keep = s_out;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("t6.hold", 32'(done), 1);
            check("t6.s", 32'(s_out), 32'(keep));
        end
        drop("t6");
        check("t6.keep", 32'(s_out), 32'(keep));

        run("t2", 5'b00000, 5'b00000, H0, H1, 5'b00000, 0, 1'b0);
        drop("t2");
        run("t3", 5'b00001, 5'b00000, H0, H1, 5'b10011, 3, 1'b0);
        drop("t3");
        run("t4", 5'b01100, 5'b00010, H0_E, H1, 5'b00000, 0, 1'b1);
        drop("t4");

        @(negedge clk);
        c0 = 5'b01100; c1 = 5'b00010; h0 = H0; h1 = H1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t5.rst.done", 32'(done), 0);
        check("t5.rst.err", 32'(err), 0);
        #2 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 2 * LAT; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("t5.nodone", 32'(seen), 0);
        check("t5.s", 32'(s_out), 0);
        run("t5b", 5'b00001, 5'b00000, H0, H1, 5'b10011, 3, 1'b0);
        drop("t5b");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
